// File: rtl/bcd_counter.sv
// N-digit BCD up/down counter with clear, validated parallel load and wrap/saturate limits.
// Carry and borrow ripple through per-digit logic; no arithmetic wider than one digit.
module bcd_counter #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                en,
    input  logic                up,
    output logic [4*DIGITS-1:0] bcd_q,
    output logic                limit,
    output logic                load_err,
    output logic                is_zero,
    output logic                is_max
);

    localparam int W = 4 * DIGITS;

    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic [DIGITS-1:0] digit_ok;
    logic              at_max;
    logic              at_zero;
    logic              load_ok;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d;
        logic [3:0] lv;

        assign d  = bcd_q[4*i +: 4];
        assign lv = load_value[4*i +: 4];

        assign carry[i+1]  = carry[i] & (d == 4'd9);
        assign borrow[i+1] = borrow[i] & (d == 4'd0);

        assign inc_val[4*i +: 4] = !carry[i]  ? d : (d == 4'd9) ? 4'd0 : d + 4'd1;
        assign dec_val[4*i +: 4] = !borrow[i] ? d : (d == 4'd0) ? 4'd9 : d - 4'd1;

        assign digit_ok[i] = (lv <= 4'd9);
    end

    // Full-chain carry/borrow doubles as the all-9s / all-0s decode of the register.
    assign at_max  = carry[DIGITS];
    assign at_zero = borrow[DIGITS];
    assign load_ok = &digit_ok;

    assign is_zero = at_zero;
    assign is_max  = at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q    <= '0;
            limit    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            limit    <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                bcd_q <= '0;
            end else if (load) begin
                if (load_ok)
                    bcd_q <= load_value;
                else
                    load_err <= 1'b1;
            end else if (en) begin
                // At a limit the ripple already yields the wrapped value (000 or 999).
                if (up) begin
                    if (at_max) limit <= 1'b1;
                    if (!(SATURATE && at_max))
                        bcd_q <= inc_val;
                end else begin
                    if (at_zero) limit <= 1'b1;
                    if (!(SATURATE && at_zero))
                        bcd_q <= dec_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter: 3-digit wrap and saturate builds side by side,
// plus 1/4/6-digit instances swept against a decimal reference model.
module tb_bcd_counter;

    logic clk;
    logic rst_n;

    // 3-digit wrap (u_wrap) and saturate (u_sat) share stimulus
    logic        clr, load, en, up;
    logic [11:0] lv3;
    logic [11:0] q_w, q_s;
    logic        lim_w, lerr_w, z_w, m_w;
    logic        lim_s, lerr_s, z_s, m_s;

    // sweep instances
    logic        clr_p, load_p, en1, en4, en6;
    logic [3:0]  lv1;
    logic [15:0] lv4;
    logic [23:0] lv6;
    logic [3:0]  q1;
    logic [15:0] q4;
    logic [23:0] q6;
    logic        lim1, lerr1, z1, mx1;
    logic        lim4, lerr4, z4, mx4;
    logic        lim6, lerr6, z6, mx6;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_counter #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_value(lv3),
        .en(en), .up(up), .bcd_q(q_w), .limit(lim_w), .load_err(lerr_w),
        .is_zero(z_w), .is_max(m_w));

    bcd_counter #(.DIGITS(3), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_value(lv3),
        .en(en), .up(up), .bcd_q(q_s), .limit(lim_s), .load_err(lerr_s),
        .is_zero(z_s), .is_max(m_s));

    bcd_counter #(.DIGITS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr_p), .load(load_p), .load_value(lv1),
        .en(en1), .up(1'b1), .bcd_q(q1), .limit(lim1), .load_err(lerr1),
        .is_zero(z1), .is_max(mx1));

    bcd_counter #(.DIGITS(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clr(clr_p), .load(load_p), .load_value(lv4),
        .en(en4), .up(1'b1), .bcd_q(q4), .limit(lim4), .load_err(lerr4),
        .is_zero(z4), .is_max(mx4));

    bcd_counter #(.DIGITS(6)) u_d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr_p), .load(load_p), .load_value(lv6),
        .en(en6), .up(1'b1), .bcd_q(q6), .limit(lim6), .load_err(lerr6),
        .is_zero(z6), .is_max(mx6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk3(input string tag, input logic [11:0] ew, input logic [11:0] es,
                        input logic elw, input logic els);
        chk({tag, " wrap q"}, 32'(q_w), 32'(ew));
        chk({tag, " sat q"},  32'(q_s), 32'(es));
        chk({tag, " wrap limit"}, 32'(lim_w), 32'(elw));
        chk({tag, " sat limit"},  32'(lim_s), 32'(els));
    endtask

    initial begin
        int m, mod, pulses;
        rst_n = 1'b0;
        clr = 0; load = 0; en = 0; up = 1; lv3 = '0;
        clr_p = 0; load_p = 0; en1 = 0; en4 = 0; en6 = 0;
        lv1 = '0; lv4 = '0; lv6 = '0;
        #12;
        chk("reset q", 32'(q_w), 32'h000);
        chk("reset limit", 32'(lim_w), 32'd0);
        chk("reset load_err", 32'(lerr_w), 32'd0);
        chk("reset is_zero", 32'(z_w), 32'd1);
        chk("reset is_max", 32'(m_w), 32'd0);
        rst_n = 1'b1;

        // asynchronous reset mid-operation
        load = 1; lv3 = 12'h457; step();
        chk("load 457", 32'(q_w), 32'h457);
        load = 0; en = 1; up = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset q", 32'(q_w), 32'h000);
        chk("async reset is_zero", 32'(z_w), 32'd1);
        #1 rst_n = 1'b1;
        step(); step(); step();
        chk3("3 steps after reset", 12'h003, 12'h003, 0, 0);

        // increment ripple
        en = 0; load = 1; lv3 = 12'h099; step();
        load = 0; en = 1; up = 1; step();
        chk3("inc 099", 12'h100, 12'h100, 0, 0);
        en = 0; load = 1; lv3 = 12'h999; step();
        load = 0;
        chk("is_max at 999", 32'(m_w), 32'd1);
        chk("is_zero at 999", 32'(z_w), 32'd0);
        en = 1; step();
        chk3("inc 999", 12'h000, 12'h999, 1, 1);
        chk("is_max after wrap", 32'(m_w), 32'd0);
        step();
        chk3("inc again", 12'h001, 12'h999, 0, 1);
        en = 0; step();
        chk3("idle", 12'h001, 12'h999, 0, 0);

        // decrement borrow
        load = 1; lv3 = 12'h100; step();
        load = 0; en = 1; up = 0; step();
        chk3("dec 100", 12'h099, 12'h099, 0, 0);
        en = 0; clr = 1; step();
        clr = 0; en = 1; up = 0; step();
        chk3("dec 000", 12'h999, 12'h000, 1, 1);
        en = 0; step();

        // invalid load
        load = 1; lv3 = 12'h123; step();
        lv3 = 12'h1A5; step();
        chk("bad load q", 32'(q_w), 32'h123);
        chk("bad load load_err", 32'(lerr_w), 32'd1);
        lv3 = 12'h905; step();
        chk("good load q", 32'(q_w), 32'h905);
        chk("good load load_err", 32'(lerr_w), 32'd0);
        load = 0; step();
        chk("load_err clears", 32'(lerr_w), 32'd0);

        // priority
        clr = 1; load = 1; en = 1; up = 1; lv3 = 12'h555; step();
        chk3("clr+load+en", 12'h000, 12'h000, 0, 0);
        chk("clr load_err", 32'(lerr_w), 32'd0);
        clr = 0; step();
        chk3("load+en", 12'h555, 12'h555, 0, 0);
        lv3 = 12'h999; step();
        lv3 = 12'hF99; step();
        chk3("bad load+en at max", 12'h999, 12'h999, 0, 0);
        chk("bad load+en load_err", 32'(lerr_s), 32'd1);
        load = 0; en = 0; step();

        // sweep: 1 digit, 10^1+5 increments from 0
        clr_p = 1; step(); clr_p = 0;
        m = 0; mod = 10; pulses = 0; en1 = 1;
        for (int n = 0; n < 15; n++) begin
            step();
            m = (m + 1) % mod;
            if (lim1) pulses++;
            chk("d1 sweep q", 32'(q1), to_bcd(m));
            chk("d1 sweep is_max", 32'(mx1), 32'(m == mod - 1));
        end
        en1 = 0;
        chk("d1 limit pulses", 32'(pulses), 32'd1);

        // sweep: 4 digits, 10^4+5 increments from 0
        m = 0; mod = 10000; pulses = 0; en4 = 1;
        for (int n = 0; n < 10005; n++) begin
            step();
            m = (m + 1) % mod;
            if (lim4) pulses++;
            if (q4 !== to_bcd(m)[15:0] || mx4 !== (m == mod - 1) || n % 1000 == 0)
                chk("d4 sweep q/is_max", {15'd0, mx4, q4}, {15'd0, 1'(m == mod - 1), to_bcd(m)[15:0]});
        end
        en4 = 0;
        chk("d4 final q", 32'(q4), 32'h0005);
        chk("d4 limit pulses", 32'(pulses), 32'd1);

        // 6 digits: full sweep is too long, so run through the wrap from near the top
        chk("d6 q before load", 32'(q6), 32'h000000);
        load_p = 1; lv1 = 4'h0; lv4 = 16'h0000; lv6 = 24'h999995; step(); load_p = 0;
        m = 999995; mod = 1000000; pulses = 0; en6 = 1;
        for (int n = 0; n < 10; n++) begin
            step();
            m = (m + 1) % mod;
            if (lim6) pulses++;
            chk("d6 wrap q", 32'(q6), to_bcd(m));
            chk("d6 wrap is_max", 32'(mx6), 32'(m == mod - 1));
        end
        en6 = 0;
        chk("d6 limit pulses", 32'(pulses), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_counter.md
# bcd_counter

Parametrised N-digit BCD up/down counter with synchronous clear, parallel load, wrap or saturate limit handling, and registered status flags. It generalises the team's 3-digit combinational BCD incrementor into a clocked, width-configurable counter. Typical uses are event counters, timers and display-driving tallies that feed BCD-to-seven-segment logic directly.

## Interface
- `DIGITS`, default 3: number of BCD digits, ≥1. Count width is W = 4·DIGITS.
- `SATURATE`, default 0: 0 = wrap at limits; 1 = hold at limits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `clr` input 1: synchronous clear to zero.
- `load` input 1: synchronous parallel load.
- `load_value` input W: BCD value to load; digit i is bits [4i+3:4i], and digit 0 is least significant.
- `en` input 1: count enable; one step per enabled cycle.
- `up` input 1: 1 = increment, 0 = decrement. Sampled only when `en` is high.
- `bcd_q` output W: current count, registered, always valid BCD.
- `limit` output 1: one-cycle pulse; an enabled step hit a limit (overflow or underflow).
- `load_err` output 1: one-cycle pulse; a load was rejected because of an invalid digit.
- `is_zero` output 1: high when `bcd_q` equals all zero digits.
- `is_max` output 1: high when every digit of `bcd_q` is 9.

## Operation
- Per-cycle priority is `clr` > `load` > `en`. When none of these is asserted, the count holds.
- **Clear:** `bcd_q` ← 0. `limit` and `load_err` are 0 that cycle.
- **Load:**
  - If every digit of `load_value` is ≤9, then `bcd_q` ← `load_value`.
  - If any digit is >9 (A–F), `bcd_q` holds its value and `load_err` pulses.
  - Load always overrides `en` in the same cycle, whether accepted or rejected; no count step occurs.
- **Increment (`en`=1, `up`=1):**
  - Digit 0 adds 1. A digit at 9 becomes 0 and carries into the next digit.
  - A carry ripples through consecutive 9s only.
  - At the all-9s value with `SATURATE`=0: `bcd_q` ← 0 and `limit` pulses.
  - At the all-9s value with `SATURATE`=1: `bcd_q` holds and `limit` pulses.
- **Decrement (`en`=1, `up`=0):**
  - Digit 0 subtracts 1. A digit at 0 becomes 9 and borrows from the next digit.
  - At zero with `SATURATE`=0: `bcd_q` ← all-9s and `limit` pulses.
  - At zero with `SATURATE`=1: `bcd_q` holds and `limit` pulses.
- **Carry chain:** built from per-digit logic generated over `DIGITS`. There is no binary-to-BCD conversion and no arithmetic wider than 4 bits per digit.
- **Flags:**
  - `is_zero` and `is_max` are decoded from the `bcd_q` register, so they are glitch-free with respect to the state.
  - `is_zero` and `is_max` are never both high.
- **Invariant:** `bcd_q` never holds a non-BCD digit.

## Timing
- **Reset (`rst_n` low):** asynchronous. `bcd_q`=0, `limit`=0, `load_err`=0, `is_zero`=1, `is_max`=0.
- **Reset release:** the first count step can occur on the first rising edge after `rst_n` goes high.
- **Reset mid-operation:** takes effect immediately, independent of `clk`. Any pending step is discarded.
- **Latency:** one cycle. Inputs sampled on edge k are reflected in `bcd_q` after edge k.
- **Pulse alignment:**
  - `limit` and `load_err` are registered and go high in the same cycle as the corresponding `bcd_q` update.
  - They are high for exactly one cycle per event.
  - Back-to-back events produce back-to-back pulses.
- **Continuous counting:** with `en` held high, the counter advances every cycle with no bubbles. Wrap is seamless: …998, 999, 000, 001…
- **Direction changes:** `up` may change on any cycle; each step uses the value sampled that cycle.
- **Simultaneous events:**
  - `clr` with `load` or `en`: clear wins and no pulses occur.
  - `load` with `en`: load wins and `limit` stays 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-count at `bcd_q`=0x457 → `bcd_q`=0x000 and `is_zero`=1 without a clock edge. Release, then 3 cycles of `en`=1, `up`=1 → 0x003.
- **Increment ripple (`DIGITS`=3):** load 0x099, then `en`=1, `up`=1 → 0x100. Load 0x999 and increment → 0x000 with a `limit` pulse for exactly one cycle. Repeat with `SATURATE`=1 → 0x999 held, with a `limit` pulse on each enabled cycle.
- **Decrement borrow:** load 0x100 and decrement → 0x099. From 0x000, decrement → 0x999 with `limit` (wrap build), or 0x000 with `limit` (saturate build).
- **Invalid load:** from 0x123, load 0x1A5 → `bcd_q` stays 0x123 and `load_err`=1 for one cycle. Then load 0x905 → accepted, `load_err`=0.
- **Priority:** drive `clr`=`load`=`en`=1 with `load_value`=0x555 → 0x000. Drive `load`=`en`=1 → 0x555 and `limit`=0.
- **Parametric sweep:** `DIGITS`=1, 4 and 6, run 10^`DIGITS`+5 increments from 0 → the count matches a decimal reference model modulo 10^`DIGITS`, with exactly one `limit` pulse. Also check `is_max` is high only at the all-9s value.
